// File: rtl/semimips_pkg.sv
// semimips_pkg: shared constants and bundles for the semiMIPS pipeline.
// Holds the IF/ID bundle type and the word-alignment helper.
package semimips_pkg;

   localparam int          WORD_W           = 32;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] PC_INC           = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc4;
      logic              valid;
   } ifid_t;

   function automatic logic [WORD_W-1:0] align_word(
      input logic [WORD_W-1:0] a
   );
      return {a[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifid_register.sv
// ifid_register: IF/ID pipeline register.
// Write-enable gates both load and flush; flush inserts a NOP bubble.
module ifid_register
   import semimips_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  i_we,
   input  logic  i_flush,
   input  ifid_t i_d,
   output ifid_t o_q
);

   ifid_t r_q;

   // Hold when disabled; bubble on flush; otherwise load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q.instr <= NOP_INSTR;
         r_q.pc4   <= '0;
         r_q.valid <= 1'b0;
      end else if (i_we) begin
         if (i_flush) begin
            r_q.instr <= NOP_INSTR;
            r_q.pc4   <= '0;
            r_q.valid <= 1'b0;
         end else begin
            r_q <= i_d;
         end
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: semiMIPS IF stage with PC, next-PC mux and IF/ID.
// Also keeps saturating stall and flush event counters.
module fetch_stage
   import semimips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pcen,
   input  logic             ifidregwr,
   input  logic             branch_taken,
   input  logic [31:0]      branch_target,
   input  logic             jump,
   input  logic [31:0]      jump_target,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      ifid_instr,
   output logic [31:0]      ifid_pc4,
   output logic             ifid_valid,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [31:0]      r_pc;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic [31:0]      w_pc4;
   logic [31:0]      w_next_pc;
   logic             w_pcen;
   logic             w_ifidwr;
   logic             w_redirect;
   logic             w_flush;
   ifid_t            w_ifid_d;
   ifid_t            w_ifid_q;

   // Undriven hazard-unit enables count as "go"
   assign w_pcen     = (pcen !== 1'b0);
   assign w_ifidwr   = (ifidregwr !== 1'b0);
   assign w_redirect = jump | branch_taken;
   assign w_flush    = w_ifidwr & w_redirect;
   assign w_pc4      = r_pc + PC_INC;

   // Next-PC select: jump beats branch beats sequential
   always_comb begin
      w_next_pc = w_pc4;
      if (jump) begin
         w_next_pc = align_word(jump_target);
      end else if (branch_taken) begin
         w_next_pc = align_word(branch_target);
      end
   end

   // PC register, frozen while the hazard unit stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else if (w_pcen) begin
         r_pc <= w_next_pc;
      end
   end

   // Saturating stall and flush counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!w_pcen && r_stall_cnt != CNT_MAX) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
         if (w_flush && r_flush_cnt != CNT_MAX) begin
            r_flush_cnt <= r_flush_cnt + 1'b1;
         end
      end
   end

   assign w_ifid_d.instr = imem_rdata;
   assign w_ifid_d.pc4   = w_pc4;
   assign w_ifid_d.valid = 1'b1;

   ifid_register u_ifid (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_ifidwr),
      .i_flush (w_redirect),
      .i_d     (w_ifid_d),
      .o_q     (w_ifid_q)
   );

   assign imem_addr  = r_pc;
   assign ifid_instr = w_ifid_q.instr;
   assign ifid_pc4   = w_ifid_q.pc4;
   assign ifid_valid = w_ifid_q.valid;
   assign stall_cnt  = r_stall_cnt;
   assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench with a queued reference model.
// Narrow counters make saturation reachable in a short run.
module tb_fetch_stage;

   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          pcen;
   logic          ifidregwr;
   logic          branch_taken;
   logic [31:0]   branch_target;
   logic          jump;
   logic [31:0]   jump_target;
   logic [31:0]   imem_addr;
   logic [31:0]   imem_rdata;
   logic [31:0]   ifid_instr;
   logic [31:0]   ifid_pc4;
   logic          ifid_valid;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      int          st;
      int          fl;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pc4;
   logic        m_valid;
   int          m_st;
   int          m_fl;
   int          total = 0;
   int          bad = 0;

   fetch_stage #(
      .RESET_PC (32'h0000_0000),
      .CNT_W    (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pcen          (pcen),
      .ifidregwr     (ifidregwr),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .ifid_instr    (ifid_instr),
      .ifid_pc4      (ifid_pc4),
      .ifid_valid    (ifid_valid),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   assign imem_rdata = mem(imem_addr);

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, o, e);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      chk({tag, ".pc"},    imem_addr, e.pc);
      chk({tag, ".instr"}, ifid_instr, e.instr);
      chk({tag, ".pc4"},   ifid_pc4, e.pc4);
      chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e.valid});
      chk({tag, ".stall"}, {30'd0, stall_cnt}, e.st);
      chk({tag, ".flush"}, {30'd0, flush_cnt}, e.fl);
   endtask

   function automatic exp_t snap();
      exp_t e;
      e.pc    = m_pc;
      e.instr = m_instr;
      e.pc4   = m_pc4;
      e.valid = m_valid;
      e.st    = m_st;
      e.fl    = m_fl;
      return e;
   endfunction

   task automatic model_reset();
      m_pc    = 32'h0;
      m_instr = 32'h0;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
      m_st    = 0;
      m_fl    = 0;
   endtask

   task automatic cyc(input string tag, input logic pe, input logic we,
                      input logic jp, input logic [31:0] jt,
                      input logic br, input logic [31:0] bt);
      logic [31:0] npc;
      exp_t        e;
      pcen          = pe;
      ifidregwr     = we;
      jump          = jp;
      jump_target   = jt;
      branch_taken  = br;
      branch_target = bt;
      #1;
      chk({tag, ".addr_pre"}, imem_addr, m_pc);
      if (jp) npc = {jt[31:2], 2'b00};
      else if (br) npc = {bt[31:2], 2'b00};
      else npc = m_pc + 32'd4;
      if (we) begin
         if (jp || br) begin
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
            if (m_fl < CMAX) m_fl++;
         end else begin
            m_instr = mem(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
         end
      end
      if (!pe) begin
         if (m_st < CMAX) m_st++;
      end else begin
         m_pc = npc;
      end
      sbq.push_back(snap());
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      check_all(tag, e);
   endtask

   task automatic nrm(input string tag);
      cyc(tag, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      pcen = 1'b1;
      ifidregwr = 1'b1;
      jump = 1'b0;
      jump_target = 32'h0;
      branch_taken = 1'b0;
      branch_target = 32'h0;
      model_reset();
      #3;
      check_all("rst0", snap());
      #9;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("t1.addr", imem_addr, 32'h4);
      chk("t1.pc4", ifid_pc4, 32'h4);
      chk("t1.valid", {31'd0, ifid_valid}, 32'd1);
      chk("t1.instr", ifid_instr, mem(32'h0));
      m_pc    = 32'h4;
      m_instr = mem(32'h0);
      m_pc4   = 32'h4;
      m_valid = 1'b1;
      nrm("t1a");
      nrm("t1b");
      nrm("t1c");
      chk("t2.pre", imem_addr, 32'h10);
      cyc("t2.stall", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("t2.hold", imem_addr, 32'h10);
      chk("t2.ifid", ifid_pc4, 32'h10);
      nrm("t2.res");
      chk("t2.res_pc4", ifid_pc4, 32'h14);
      nrm("t2a");
      nrm("t2b");
      nrm("t2c");
      chk("t3.pre", imem_addr, 32'h20);
      cyc("t3.br", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h103);
      chk("t3.pc", imem_addr, 32'h100);
      nrm("t3.fetch");
      chk("t3.instr", ifid_instr, mem(32'h100));
      cyc("t4.jb", 1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300);
      chk("t4.pc", imem_addr, 32'h200);
      chk("t4.fl", {30'd0, flush_cnt}, 32'd2);
      nrm("t4.fetch");
      cyc("t5.hold", 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
      chk("t5.pc", imem_addr, 32'h204);
      cyc("t5.go", 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
      chk("t5.pc2", imem_addr, 32'h40);
      cyc("t5.sat", 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
      chk("t5.flsat", {30'd0, flush_cnt}, CMAX);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all("t6.async", snap());
      @(posedge clk);
      #3;
      rst = 1'b0;
      cyc("t6.jmax", 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
      chk("t6.top", imem_addr, 32'hFFFF_FFFC);
      nrm("t6.wrap");
      chk("t6.zero", imem_addr, 32'h0);
      chk("t6.pc4w", ifid_pc4, 32'h0);
      for (int i = 0; i < 4; i++) begin
         cyc("t6.stall", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      end
      chk("t6.stsat", {30'd0, stall_cnt}, CMAX);
      nrm("t6.end");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
